// File: rtl/ir_beacon_if.sv
// Control/LED-side signal bundle for the IR beacon transmitter.
// master = control logic, slave = ir_beacon_tx.
interface ir_beacon_if;
    logic [2:0] freq_sel;
    logic [7:0] burst_len;
    logic       start;
    logic       stop;
    logic       ir_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] cur_sel;

    modport master (
        output freq_sel, burst_len, start, stop,
        input  ir_out, busy, done, err, cur_sel
    );

    modport slave (
        input  freq_sel, burst_len, start, stop,
        output ir_out, busy, done, err, cur_sel
    );
endinterface

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: square wave at one of four rates, finite burst or continuous.
// Define IR_CARRIER_EN to modulate the HIGH phase with a CAR_HALF-cycle carrier.
module ir_beacon_tx #(
    parameter int HALF_1   = 250000,
    parameter int HALF_2   = 50000,
    parameter int HALF_3   = 10000,
    parameter int HALF_4   = 7143,
    parameter int CNT_W    = 20,
    parameter int CAR_HALF = 1316
) (
    input logic        clk,
    input logic        rst,
    ir_beacon_if.slave bus
);
    // state  | meaning
    // S_IDLE | waiting for a valid start
    // S_HIGH | LED phase on (carrier-modulated when enabled)
    // S_LOW  | LED phase off; period counted at its end
    // S_DONE | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    localparam logic [CNT_W-1:0] L_H1_M1 = CNT_W'(HALF_1 - 1);
    localparam logic [CNT_W-1:0] L_H2_M1 = CNT_W'(HALF_2 - 1);
    localparam logic [CNT_W-1:0] L_H3_M1 = CNT_W'(HALF_3 - 1);
    localparam logic [CNT_W-1:0] L_H4_M1 = CNT_W'(HALF_4 - 1);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

`ifdef IR_CARRIER_EN
    localparam int              CAR_W    = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;
    localparam logic [CAR_W-1:0] L_CAR_M1 = CAR_W'(CAR_HALF - 1);
    localparam logic [CAR_W-1:0] L_CAR_ONE = CAR_W'(1);
    logic [CAR_W-1:0] r_car;
`else
    logic w_unused_car;
    assign w_unused_car = (CAR_HALF == 0);
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half_m1;
    logic [7:0]       r_len;
    logic [7:0]       r_per;
    logic             r_ir_out;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [2:0]       r_cur_sel;

    logic             w_sel_ok;
    logic [CNT_W-1:0] w_sel_half_m1;
    logic [7:0]       w_per_nxt;

    always_comb begin
        w_sel_ok      = 1'b1;
        w_sel_half_m1 = L_H1_M1;
        case (bus.freq_sel)
            3'd1:    w_sel_half_m1 = L_H1_M1;
            3'd2:    w_sel_half_m1 = L_H2_M1;
            3'd3:    w_sel_half_m1 = L_H3_M1;
            3'd4:    w_sel_half_m1 = L_H4_M1;
            default: begin
                w_sel_ok      = 1'b0;
                w_sel_half_m1 = '0;
            end
        endcase
    end

    // 8-bit period count wraps harmlessly in continuous mode
    assign w_per_nxt = r_per + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_half_m1 <= '0;
            r_len     <= '0;
            r_per     <= '0;
            r_ir_out  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cur_sel <= '0;
`ifdef IR_CARRIER_EN
            r_car     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (w_sel_ok) begin
                            r_state   <= S_HIGH;
                            r_cur_sel <= bus.freq_sel;
                            r_len     <= bus.burst_len;
                            r_half_m1 <= w_sel_half_m1;
                            r_cnt     <= w_sel_half_m1;
                            r_per     <= '0;
                            r_ir_out  <= 1'b1;
                            r_busy    <= 1'b1;
`ifdef IR_CARRIER_EN
                            r_car     <= L_CAR_M1;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (bus.stop) begin
                        r_state   <= S_DONE;
                        r_ir_out  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_cur_sel <= '0;
                    end else if (r_cnt == '0) begin
                        r_state  <= S_LOW;
                        r_ir_out <= 1'b0;
                        r_cnt    <= r_half_m1;
                    end else begin
                        r_cnt <= r_cnt - L_ONE;
`ifdef IR_CARRIER_EN
                        if (r_car == '0) begin
                            r_car    <= L_CAR_M1;
                            r_ir_out <= ~r_ir_out;
                        end else begin
                            r_car <= r_car - L_CAR_ONE;
                        end
`endif
                    end
                end
                S_LOW: begin
                    if (bus.stop) begin
                        r_state   <= S_DONE;
                        r_ir_out  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_cur_sel <= '0;
                    end else if (r_cnt == '0) begin
                        r_per <= w_per_nxt;
                        if (r_len != 8'd0 && w_per_nxt == r_len) begin
                            r_state   <= S_DONE;
                            r_ir_out  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_cur_sel <= '0;
                        end else begin
                            r_state  <= S_HIGH;
                            r_ir_out <= 1'b1;
                            r_cnt    <= r_half_m1;
`ifdef IR_CARRIER_EN
                            r_car    <= L_CAR_M1;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - L_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ir_out  = r_ir_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.cur_sel = r_cur_sel;
endmodule
